infoframe_packet_builder: RTL and testbench

Parametrised, runtime-programmable generator for HDMI InfoFrame packets (AVI, SPD, Audio, Vendor). It generalises fixed-content InfoFrame modules into one generic builder. Software or control logic writes payload bytes into a shadow buffer, then pulses commit. A sequential checksum engine then atomically publishes a new header/subpacket set to the packet picker, with no mid-frame tearing.

---
 rtl/infoframe_packet_builder.sv | 119 +++++++++++
 tb/tb_infoframe_packet_builder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/infoframe_packet_builder.sv
// Generic HDMI InfoFrame builder: shadow payload, sequential checksum, atomic publish.
// Optional INFOFRAME_DIRTY_FLAG_EN adds a 'dirty' output for unpublished shadow writes.
module infoframe_packet_builder #(
  parameter logic [6:0] TYPE    = 7'd2,
  parameter logic [7:0] VERSION = 8'd2,
  parameter logic [4:0] LENGTH  = 5'd13
) (
  input  logic             clk_pixel,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [7:0]       wr_data,
  input  logic             commit,
`ifdef INFOFRAME_DIRTY_FLAG_EN
  output logic             dirty,
`endif
  output logic             busy,
  output logic             frame_valid,
  output logic [23:0]      header,
  output logic [3:0][55:0] sub
);
  localparam int         LEN       = int'(LENGTH);
  localparam logic [7:0] HB0       = {1'b1, TYPE};
  localparam logic [7:0] HB2       = {3'b000, LENGTH};
  localparam logic [7:0] HDR_SUM   = HB0 + VERSION + HB2;
  localparam logic [7:0] RESET_PB0 = 8'd0 - HDR_SUM;

  typedef enum logic [1:0] {IDLE, SUM, SWAP} state_t;

  state_t       state, state_next;
  logic [7:0]   acc;
  logic [4:0]   idx;
  logic [7:0]   sum_byte;
  logic         wr_accept;
  logic [223:0] flat;
  logic [7:0]   shadow [1:LEN];
  logic [7:0]   active [0:LEN];

  // Writes only land while idle, so the summed bytes cannot change under the engine.
  assign wr_accept = wr_en && (state == IDLE) && (wr_addr != 5'd0) && (wr_addr <= LENGTH);
  assign header    = {HB2, VERSION, HB0};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (commit) state_next = SUM;
      SUM:     if (idx == LENGTH) state_next = SWAP;
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    sum_byte = 8'd0;
    for (int i = 1; i <= LEN; i++) begin
      if (idx == 5'(i)) sum_byte = shadow[i];
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      acc         <= 8'd0;
      idx         <= 5'd0;
      busy        <= 1'b0;
      frame_valid <= 1'b0;
      for (int i = 1; i <= LEN; i++) begin
        shadow[i] <= 8'd0;
        active[i] <= 8'd0;
      end
      active[0] <= RESET_PB0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      for (int i = 1; i <= LEN; i++) begin
        if (wr_accept && (wr_addr == 5'(i))) shadow[i] <= wr_data;
      end
      case (state)
        IDLE: begin
          if (commit) begin
            acc <= HDR_SUM;
            idx <= 5'd1;
          end
        end
        SUM: begin
          acc <= acc + sum_byte;
          idx <= idx + 5'd1;
        end
        SWAP: begin
          // Payload and checksum move together on this single edge.
          for (int i = 1; i <= LEN; i++) active[i] <= shadow[i];
          active[0]   <= 8'd0 - acc;
          frame_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef INFOFRAME_DIRTY_FLAG_EN
  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      dirty <= 1'b0;
    end else if ((state == IDLE) && commit) begin
      dirty <= 1'b0;
    end else if (wr_accept) begin
      dirty <= 1'b1;
    end
  end
`endif

  // Bytes above LENGTH stay zero in the published subpackets.
  always_comb begin
    flat = '0;
    for (int b = 0; b <= LEN; b++) flat[b*8 +: 8] = active[b];
    sub = flat;
  end

endmodule

// File: tb/tb_infoframe_packet_builder.sv
// Scoreboard bench for infoframe_packet_builder: default build plus a LENGTH=25 instance.
module tb_infoframe_packet_builder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n;
  logic             wr_en, commit, wr_en2, commit2;
  logic [4:0]       wr_addr, wr_addr2;
  logic [7:0]       wr_data, wr_data2;
  logic             busy, frame_valid, busy2, frame_valid2;
  logic [23:0]      header, header2;
  logic [3:0][55:0] sub, sub2;
`ifdef INFOFRAME_DIRTY_FLAG_EN
  logic             dirty, dirty2;
`endif

  int errors = 0;
  int checks = 0;
  logic [223:0] exp_q[$];
  logic [223:0] exp_q2[$];
  logic [223:0] pl, pl2;

  localparam logic [23:0] HDR1 = 24'h0D0282;
  localparam logic [23:0] HDR2 = 24'h190183;

  infoframe_packet_builder dut (
    .clk_pixel(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .commit(commit),
`ifdef INFOFRAME_DIRTY_FLAG_EN
    .dirty(dirty),
`endif
    .busy(busy), .frame_valid(frame_valid), .header(header), .sub(sub)
  );

  infoframe_packet_builder #(.TYPE(7'd3), .VERSION(8'd1), .LENGTH(5'd25)) dut2 (
    .clk_pixel(clk), .reset_n(reset_n), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .commit(commit2),
`ifdef INFOFRAME_DIRTY_FLAG_EN
    .dirty(dirty2),
`endif
    .busy(busy2), .frame_valid(frame_valid2), .header(header2), .sub(sub2)
  );

  task automatic check(input string name, input logic [223:0] act, input logic [223:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte sum of header plus all 28 payload slots; a correct frame sums to zero.
  function automatic logic [7:0] bsum(input logic [23:0] h, input logic [223:0] s);
    logic [7:0] t;
    t = h[7:0] + h[15:8] + h[23:16];
    for (int b = 0; b < 28; b++) t += s[b*8 +: 8];
    return t;
  endfunction

  function automatic logic [223:0] expect_frame(input logic [223:0] p, input logic [23:0] h);
    logic [223:0] f;
    f = p;
    f[7:0] = 8'd0 - bsum(h, {p[223:8], 8'd0});
    return f;
  endfunction

  task automatic write(input logic [4:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic write2(input logic [4:0] a, input logic [7:0] d);
    wr_en2 = 1'b1; wr_addr2 = a; wr_data2 = d;
    @(posedge clk); #1;
    wr_en2 = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(posedge clk); #1;
    commit = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin @(posedge clk); #1; n++; end
    if (busy) begin checks++; errors++; $display("FAIL busy_timeout: busy still %b after %0d cycles", busy, n); end
  endtask

  task automatic wait_idle2();
    int n;
    n = 0;
    while (busy2 && n < 60) begin @(posedge clk); #1; n++; end
    if (busy2) begin checks++; errors++; $display("FAIL busy2_timeout: busy still %b after %0d cycles", busy2, n); end
  endtask

  // Monitor for the default instance: a frame is published when busy falls.
  initial begin : monitor
    int cnt;
    logic prev;
    logic [223:0] e;
    cnt = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cnt = 0; prev = 1'b0;
      end else begin
        if (busy) cnt++;
        else if (prev) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame: got %h expected none", sub);
          end else begin
            e = exp_q.pop_front();
            check("frame_sub", sub, e);
            check("busy_cycles", 224'(cnt), 224'(14));
            check("frame_valid", 224'(frame_valid), 224'(1));
            check("checksum_zero", 224'(bsum(header, sub)), 224'(0));
          end
          cnt = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin : monitor2
    int cnt;
    logic prev;
    logic [223:0] e;
    cnt = 0; prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        cnt = 0; prev = 1'b0;
      end else begin
        if (busy2) cnt++;
        else if (prev) begin
          if (exp_q2.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_frame2: got %h expected none", sub2);
          end else begin
            e = exp_q2.pop_front();
            check("frame2_sub", sub2, e);
            check("busy2_cycles", 224'(cnt), 224'(26));
            check("checksum2_zero", 224'(bsum(header2, sub2)), 224'(0));
            check("sub2_above_pb25", 224'(sub2[3][55:40]), 224'(0));
          end
          cnt = 0;
        end
        prev = busy2;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    reset_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; commit = 1'b0;
    wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0; commit2 = 1'b0;
    pl = '0; pl2 = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset state.
    check("reset_header", 224'(header), 224'(HDR1));
    check("reset_sub", sub, 224'h6F);
    check("reset_busy", 224'(busy), 224'(0));
    check("reset_frame_valid", 224'(frame_valid), 224'(0));
    check("reset_header2", 224'(header2), 224'(HDR2));
    check("reset_sub2", sub2, 224'h63);
`ifdef INFOFRAME_DIRTY_FLAG_EN
    check("reset_dirty", 224'(dirty), 224'(0));
`endif

    // Basic write and commit.
    write(5'd1, 8'h02); pl[8 +: 8] = 8'h02;
`ifdef INFOFRAME_DIRTY_FLAG_EN
    check("dirty_after_write", 224'(dirty), 224'(1));
`endif
    write(5'd2, 8'h08); pl[16 +: 8] = 8'h08;
    write(5'd4, 8'h01); pl[32 +: 8] = 8'h01;
    exp_q.push_back(expect_frame(pl, HDR1));
    pulse_commit();
    check("busy_after_commit", 224'(busy), 224'(1));
    wait_idle();
    check("sub0_hand", 224'(sub[0]), 224'(56'h00000100080264));

    // Write during busy plus out-of-range idle writes are all dropped.
    exp_q.push_back(expect_frame(pl, HDR1));
    pulse_commit();
    write(5'd3, 8'hFF);
    wait_idle();
    write(5'd0, 8'hAA);
    write(5'd14, 8'h55);
    exp_q.push_back(expect_frame(pl, HDR1));
    pulse_commit();
    wait_idle();
    check("pb0_unchanged", 224'(sub[0][7:0]), 224'(8'h64));

    // Write and commit in the same cycle.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h10; commit = 1'b1;
    pl[40 +: 8] = 8'h10;
    exp_q.push_back(expect_frame(pl, HDR1));
    @(posedge clk); #1;
    wr_en = 1'b0; commit = 1'b0;
`ifdef INFOFRAME_DIRTY_FLAG_EN
    check("dirty_same_cycle_commit", 224'(dirty), 224'(0));
`endif
    wait_idle();
    check("pb0_after_pb5", 224'(sub[0][7:0]), 224'(8'h54));

    // Reset in the middle of SUM, then a clean commit.
    pulse_commit();
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("midsum_reset_sub", sub, 224'h6F);
    check("midsum_reset_busy", 224'(busy), 224'(0));
    check("midsum_reset_frame_valid", 224'(frame_valid), 224'(0));
    @(posedge clk); #1 reset_n = 1'b1;
    @(posedge clk); #1;
    pl = '0;
    exp_q.push_back(expect_frame(pl, HDR1));
    pulse_commit();
    wait_idle();

    // Long frame: all PB bytes 0xFF, plus a dropped write above LENGTH.
    for (int a = 1; a <= 25; a++) begin
      write2(5'(a), 8'hFF);
      pl2[a*8 +: 8] = 8'hFF;
    end
    write2(5'd26, 8'hFF);
    exp_q2.push_back(expect_frame(pl2, HDR2));
    commit2 = 1'b1;
    @(posedge clk); #1;
    commit2 = 1'b0;
    wait_idle2();

    repeat (3) @(posedge clk);
    check("exp_q_drained", 224'(exp_q.size()), 224'(0));
    check("exp_q2_drained", 224'(exp_q2.size()), 224'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
